// File: rtl/mii_pkg.sv
// MII receive MAC shared types and constants.
// States, error codes and CRC-32 constants.
package mii_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } state_t;

  typedef enum logic [2:0] {
    ERR_OK       = 3'd0,
    ERR_RXER     = 3'd1,
    ERR_OVERSIZE = 3'd2,
    ERR_ALIGN    = 3'd3,
    ERR_RUNT     = 3'd4,
    ERR_CRC      = 3'd5
  } err_t;

  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  localparam logic [3:0] NIB_PRE = 4'h5;
  localparam logic [3:0] NIB_SFD = 4'hD;

endpackage

// File: rtl/mii_crc32_nibble.sv
// Reflected CRC-32 update over one nibble.
// Bits are consumed LSB first.
module mii_crc32_nibble
  import mii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [3:0]  nibble,
  output logic [31:0] crc_out
);

  // four serial LFSR steps, unrolled
  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 4; i++) begin
      if (c[0] ^ nibble[i])
        c = (c >> 1) ^ CRC_POLY;
      else
        c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/mii_rx_mac.sv
// MII receive MAC: preamble/SFD hunt, byte assembly,
// FCS check, frame status and saturating counters.
module mii_rx_mac
  import mii_pkg::*;
#(
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int MIN_FRAME_BYTES = 64
) (
  input  logic        enet_rx_clk,
  input  logic        i_reset,
  input  logic        i_rx_dv,
  input  logic        i_rx_er,
  input  logic [3:0]  i_rx_data,
  output logic [7:0]  o_byte,
  output logic        o_byte_valid,
  output logic        o_sof,
  output logic        o_status_valid,
  output logic        o_frame_good,
  output logic [2:0]  o_err_code,
  output logic [15:0] o_frame_len,
  output logic [15:0] o_good_count,
  output logic [15:0] o_bad_count
);

  localparam logic [15:0] MAX_W = 16'(MAX_FRAME_BYTES);
  localparam logic [15:0] MIN_W = 16'(MIN_FRAME_BYTES);

  state_t      state, state_n;
  logic        armed, armed_n;
  logic [3:0]  nib_lo, nib_lo_n;
  logic        phase, phase_n;
  logic [15:0] byte_cnt, byte_cnt_n;
  logic [31:0] crc, crc_n, crc_nib;
  logic        rxer, rxer_n;
  logic        oversize, oversize_n;
  logic        sof_pend, sof_pend_n;
  logic        end_frame;
  err_t        err;

  logic [7:0]  byte_n;
  logic        byte_valid_n;
  logic        sof_n;
  logic        status_n;
  logic        good_n;
  logic [2:0]  code_n;
  logic [15:0] len_n;
  logic [15:0] good_cnt, good_cnt_n;
  logic [15:0] bad_cnt, bad_cnt_n;

  mii_crc32_nibble u_crc (
    .crc_in  (crc),
    .nibble  (i_rx_data),
    .crc_out (crc_nib)
  );

  // end-of-frame error classification, highest priority first
  always_comb begin
    err = ERR_OK;
    priority case (1'b1)
      rxer:                err = ERR_RXER;
      oversize:            err = ERR_OVERSIZE;
      phase:               err = ERR_ALIGN;
      byte_cnt < MIN_W:    err = ERR_RUNT;
      crc != CRC_RESIDUE:  err = ERR_CRC;
      default:             err = ERR_OK;
    endcase
  end

  // next-state, datapath and output decode
  always_comb begin
    state_n      = state;
    armed_n      = 1'b1;
    nib_lo_n     = nib_lo;
    phase_n      = phase;
    byte_cnt_n   = byte_cnt;
    crc_n        = crc;
    rxer_n       = rxer;
    oversize_n   = oversize;
    sof_pend_n   = sof_pend;
    end_frame    = 1'b0;
    byte_n       = o_byte;
    byte_valid_n = 1'b0;
    sof_n        = 1'b0;
    status_n     = 1'b0;
    good_n       = o_frame_good;
    code_n       = o_err_code;
    len_n        = o_frame_len;
    good_cnt_n   = good_cnt;
    bad_cnt_n    = bad_cnt;

    unique case (state)
      ST_IDLE: begin
        if (i_rx_dv) begin
          if (armed && i_rx_data == NIB_PRE)
            state_n = ST_PREAMBLE;
          else
            state_n = ST_DROP;
        end
      end
      ST_PREAMBLE: begin
        if (!i_rx_dv) begin
          state_n = ST_IDLE;
        end else if (i_rx_data == NIB_SFD) begin
          state_n    = ST_DATA;
          byte_cnt_n = '0;
          phase_n    = 1'b0;
          crc_n      = CRC_INIT;
          rxer_n     = 1'b0;
          oversize_n = 1'b0;
          sof_pend_n = 1'b1;
        end else if (i_rx_data != NIB_PRE) begin
          state_n = ST_DROP;
        end
      end
      ST_DATA: begin
        if (!i_rx_dv) begin
          state_n   = ST_IDLE;
          end_frame = 1'b1;
        end else begin
          crc_n = crc_nib;
          if (i_rx_er)
            rxer_n = 1'b1;
          if (!phase) begin
            nib_lo_n = i_rx_data;
            phase_n  = 1'b1;
          end else begin
            phase_n = 1'b0;
            if (byte_cnt == MAX_W) begin
              state_n    = ST_DROP;
              oversize_n = 1'b1;
              byte_cnt_n = MAX_W + 16'd1;
            end else begin
              byte_cnt_n   = byte_cnt + 16'd1;
              byte_n       = {i_rx_data, nib_lo};
              byte_valid_n = 1'b1;
              sof_n        = sof_pend;
              sof_pend_n   = 1'b0;
            end
          end
        end
      end
      ST_DROP: begin
        if (!i_rx_dv) begin
          state_n    = ST_IDLE;
          end_frame  = oversize;
          oversize_n = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (end_frame) begin
      status_n = 1'b1;
      code_n   = err;
      good_n   = (err == ERR_OK);
      len_n    = byte_cnt;
      if (err == ERR_OK) begin
        if (good_cnt != 16'hFFFF)
          good_cnt_n = good_cnt + 16'd1;
      end else begin
        if (bad_cnt != 16'hFFFF)
          bad_cnt_n = bad_cnt + 16'd1;
      end
    end
  end

  // state and output registers
  always_ff @(posedge enet_rx_clk) begin
    if (i_reset) begin
      state          <= ST_IDLE;
      armed          <= 1'b0;
      nib_lo         <= '0;
      phase          <= 1'b0;
      byte_cnt       <= '0;
      crc            <= CRC_INIT;
      rxer           <= 1'b0;
      oversize       <= 1'b0;
      sof_pend       <= 1'b0;
      o_byte         <= '0;
      o_byte_valid   <= 1'b0;
      o_sof          <= 1'b0;
      o_status_valid <= 1'b0;
      o_frame_good   <= 1'b0;
      o_err_code     <= '0;
      o_frame_len    <= '0;
      good_cnt       <= '0;
      bad_cnt        <= '0;
    end else begin
      state          <= state_n;
      armed          <= armed_n;
      nib_lo         <= nib_lo_n;
      phase          <= phase_n;
      byte_cnt       <= byte_cnt_n;
      crc            <= crc_n;
      rxer           <= rxer_n;
      oversize       <= oversize_n;
      sof_pend       <= sof_pend_n;
      o_byte         <= byte_n;
      o_byte_valid   <= byte_valid_n;
      o_sof          <= sof_n;
      o_status_valid <= status_n;
      o_frame_good   <= good_n;
      o_err_code     <= code_n;
      o_frame_len    <= len_n;
      good_cnt       <= good_cnt_n;
      bad_cnt        <= bad_cnt_n;
    end
  end

  assign o_good_count = good_cnt;
  assign o_bad_count  = bad_cnt;

endmodule

// File: doc/mii_rx_mac.md
MII_RX_MAC -- requirements
Module: mii_rx_mac

Interface
REQ-001 SHALL have parameter MAX_FRAME_BYTES, default 1518, max accepted length in bytes (DA through FCS).
REQ-002 SHALL have parameter MIN_FRAME_BYTES, default 64, min accepted length in bytes (DA through FCS).
REQ-003 SHALL have port enet_rx_clk, input, 1, clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have ports i_rx_dv (input, 1, data valid) and i_rx_er (input, 1, PHY receive error).
REQ-006 SHALL have port i_rx_data, input, 4, MII receive nibble.
REQ-007 SHALL have port o_byte, output, 8, assembled byte, FCS included.
REQ-008 SHALL have port o_byte_valid, output, 1, one-cycle strobe qualifying o_byte.
REQ-009 SHALL have port o_sof, output, 1, high together with o_byte_valid for the first byte after SFD.
REQ-010 SHALL have port o_status_valid, output, 1, one-cycle end-of-frame strobe.
REQ-011 SHALL have ports o_frame_good (output, 1), o_err_code (output, 3) and o_frame_len (output, 16, bytes), all valid while o_status_valid is high.
REQ-012 SHALL have ports o_good_count and o_bad_count, output, 16 each, saturating frame counters.

Function
REQ-013 SHALL implement states IDLE, PREAMBLE, DATA, DROP.
REQ-014 In IDLE, i_rx_dv=1 with nibble 0x5 SHALL go to PREAMBLE; i_rx_dv=1 with any other nibble SHALL go to DROP (silent).
REQ-015 In PREAMBLE, 0x5 SHALL hold; 0xD (SFD) SHALL go to DATA with byte count, nibble phase and CRC initialised; any other nibble, or i_rx_dv=0, SHALL go to DROP/IDLE silently.
REQ-016 In DATA, nibbles SHALL pair low-nibble-first into {second, first}; o_byte_valid SHALL assert the cycle after the second nibble is sampled.
REQ-017 CRC-32 SHALL be reflected (poly 0xEDB88320), init 0xFFFFFFFF, updated per nibble LSB first over all DATA nibbles including FCS; the frame passes the CRC check iff the final register equals 0xDEBB20E3.
REQ-018 i_rx_er=1 during DATA SHALL latch error flag RXER; reception SHALL continue.
REQ-019 If the byte count would exceed MAX_FRAME_BYTES, no further bytes SHALL be output; state SHALL go to DROP with flag OVERSIZE latched.
REQ-020 On i_rx_dv falling in DATA, or in a flagged DROP, o_status_valid SHALL pulse the next cycle, with o_frame_len equal to the complete bytes received, saturating at MAX_FRAME_BYTES+1 on OVERSIZE.
REQ-021 o_err_code SHALL be 0 OK, 1 RXER, 2 OVERSIZE, 3 ALIGN (odd nibble count), 4 RUNT (len < MIN_FRAME_BYTES), 5 CRC, with that priority (1 highest); o_frame_good=1 iff the code is 0.
REQ-022 A trailing odd nibble SHALL be discarded and never emitted.
REQ-023 Each status pulse SHALL increment exactly one counter, good or bad; counters SHALL saturate at 0xFFFF.
REQ-024 The FSM SHALL return to IDLE in the same cycle i_rx_dv is sampled low, so a frame starting the very next cycle SHALL be received normally.
REQ-025 DROP SHALL exit only when i_rx_dv is sampled low.

Reset
REQ-026 Reset SHALL force IDLE and clear to 0 all outputs, counters, flags and the byte count; the CRC register SHALL be set to 0xFFFFFFFF.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no status pulse.
REQ-028 If i_rx_dv is high on the first cycle after reset, the FSM SHALL go to DROP silently until i_rx_dv is sampled low.

Structure
REQ-029 Package mii_pkg SHALL hold the state enum, the error-code enum, the CRC polynomial, the init value and the residue constants.
REQ-030 Per-nibble CRC update SHALL be sub-module mii_crc32_nibble (combinational: crc_in[31:0], nibble[3:0] -> crc_out[31:0]).

Verification
REQ-031 Good frame: 15x0x5 preamble, 0xD SFD, 60-byte payload plus golden FCS -> 64 byte strobes, first with o_sof; status good=1, code 0, len 64; good_count 1.
REQ-032 Same frame with one payload bit flipped -> status code 5, len 64, bad_count 1.
REQ-033 40-byte frame with valid FCS -> code 4, len 40.
REQ-034 i_rx_er pulsed at byte 20 of a 64-byte frame -> code 1; 1600-byte frame -> exactly 1518 byte strobes, code 2, len 1519.
REQ-035 Good 64-byte frame plus one extra nibble -> 64 strobes, code 3; preamble 5,5,A -> no strobes, no status, counters unchanged.
REQ-036 Reset at byte 30, then an immediate back-to-back good frame -> no status for the aborted frame; second frame good, len 64; 0xFFFF good frames -> good_count holds 0xFFFF.
